// File: rtl/loop_count_down_nest.sv
// Three-level down-counting nested loop index generator.
// Level 0 is innermost and carries into level 1, which carries into level 2.
// Each level counts from its latched max down by its latched stride and
// stops at the last value that cannot be decremented without underflow.

// One loop level: holds latched max/stride and the running count.
module loop_cnt_lvl #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DATA_WIDTH-1:0] max_i,
  input  logic [DATA_WIDTH-1:0] stride_i,
  output logic [DATA_WIDTH-1:0] cnt_o,
  output logic                  wrap_o
);

  logic [DATA_WIDTH-1:0] max_q, stride_q, cnt_q, cnt_d;

  // Wrap when another decrement would underflow; stride 0 gives one value.
  always_comb begin
    wrap_o = (cnt_q == '0) || (cnt_q < stride_q) || (stride_q == '0);
    cnt_d  = wrap_o ? max_q : (cnt_q - stride_q);
  end

  // Count register: clear zeroes it, load latches a new pass, step advances.
  always_ff @(posedge clk) begin
    if (!reset) begin
      max_q    <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      max_q    <= max_i;
      stride_q <= stride_i;
      cnt_q    <= max_i;
    end else if (step_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

module loop_count_down_nest #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] max0,
  input  logic [DATA_WIDTH-1:0] max1,
  input  logic [DATA_WIDTH-1:0] max2,
  input  logic [DATA_WIDTH-1:0] stride0,
  input  logic [DATA_WIDTH-1:0] stride1,
  input  logic [DATA_WIDTH-1:0] stride2,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] count0,
  output logic [DATA_WIDTH-1:0] count1,
  output logic [DATA_WIDTH-1:0] count2,
  output logic                  last0,
  output logic                  last1,
  output logic                  last2,
  output logic                  busy,
  output logic                  done
);

  localparam int LVLS = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;

  logic [LVLS-1:0][DATA_WIDTH-1:0] max_v, stride_v, cnt_v;
  logic [LVLS-1:0]                 wrap_v;
  logic [LVLS:0]                   step_v;
  logic                            beat, load;

  assign max_v    = {max2, max1, max0};
  assign stride_v = {stride2, stride1, stride0};

  assign out_valid = (state_q == S_RUN);
  assign beat      = out_valid && out_ready;
  assign load      = (state_q == S_IDLE) && start;

  // Carry chain: a level steps on a beat only when every inner level wraps.
  always_comb begin
    step_v[0] = beat;
    for (int l = 0; l < LVLS; l++) step_v[l+1] = step_v[l] && wrap_v[l];
  end

  generate
    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      loop_cnt_lvl #(.DATA_WIDTH(DATA_WIDTH)) u_lvl (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear),
        .load_i   (load),
        .step_i   (step_v[l]),
        .max_i    (max_v[l]),
        .stride_i (stride_v[l]),
        .cnt_o    (cnt_v[l]),
        .wrap_o   (wrap_v[l])
      );
    end
  endgenerate

  // Next-state: the beat that wraps all three levels ends the pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (step_v[LVLS]) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; clear aborts to IDLE from anywhere without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset)     state_q <= S_IDLE;
    else if (clear) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  assign count0 = cnt_v[0];
  assign count1 = cnt_v[1];
  assign count2 = cnt_v[2];
  assign last0  = out_valid && wrap_v[0];
  assign last1  = out_valid && wrap_v[1];
  assign last2  = out_valid && wrap_v[2];
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_loop_count_down_nest.sv
// Randomized bench for loop_count_down_nest with a queue scoreboard.
// The driver pushes every expected tuple of a pass when it issues start;
// the monitor pops and compares on each accepted beat.
module tb_loop_count_down_nest;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset, clear, start, out_ready;
  logic [DW-1:0] max0, max1, max2, stride0, stride1, stride2;
  logic          out_valid, last0, last1, last2, busy, done;
  logic [DW-1:0] count0, count1, count2;

  typedef struct packed {
    logic [DW-1:0] c0, c1, c2;
    logic          l0, l1, l2;
  } tup_t;

  tup_t exp_q[$];
  int   pending_done = 0;
  int   checks = 0;
  int   errors = 0;

  logic held_v   = 1'b0;
  tup_t held     = '0;
  logic fin_prev = 1'b0;

  loop_count_down_nest #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .max0(max0), .max1(max1), .max2(max2),
    .stride0(stride0), .stride1(stride1), .stride2(stride2),
    .out_ready(out_ready), .out_valid(out_valid),
    .count0(count0), .count1(count1), .count2(count2),
    .last0(last0), .last1(last1), .last2(last2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep length of one level from its max and stride.
  function automatic int slen(input int m, input int s);
    return (s == 0) ? 1 : (m / s + 1);
  endfunction

  // Reference model: enumerate the pass as three plain nested loops.
  function automatic int push_pass(input int m0, input int m1, input int m2,
                                   input int s0, input int s1, input int s2);
    int n0, n1, n2;
    tup_t t;
    n0 = slen(m0, s0); n1 = slen(m1, s1); n2 = slen(m2, s2);
    for (int i2 = 0; i2 < n2; i2++)
      for (int i1 = 0; i1 < n1; i1++)
        for (int i0 = 0; i0 < n0; i0++) begin
          t.c0 = DW'(m0 - i0 * s0);
          t.c1 = DW'(m1 - i1 * s1);
          t.c2 = DW'(m2 - i2 * s2);
          t.l0 = (i0 == n0 - 1);
          t.l1 = (i1 == n1 - 1);
          t.l2 = (i2 == n2 - 1);
          exp_q.push_back(t);
        end
    pending_done++;
    return n0 * n1 * n2;
  endfunction

  // Monitor: score accepted beats, hold stability and done timing.
  always @(negedge clk) begin
    tup_t cur, e;
    cur = {count0, count1, count2, last0, last1, last2};
    if (!out_valid) chk("last_when_invalid", {29'd0, last0, last1, last2}, 0);
    if (held_v && out_valid) chk("hold_stable", cur, held);
    held_v = out_valid && !out_ready && reset && !clear;
    held   = cur;
    if (done) begin
      chk("done_after_final", fin_prev, 1);
      chk("done_expected", pending_done > 0, 1);
      if (pending_done > 0) pending_done--;
      chk("beats_left_at_done", exp_q.size(), 0);
    end else if (fin_prev) begin
      chk("done_missing", done, 1);
    end
    fin_prev = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat actual=%0h expected=none at %0t", cur, $time);
      end else begin
        e = exp_q.pop_front();
        chk("tuple", cur, e);
      end
      fin_prev = last0 && last1 && last2 && reset && !clear;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    pending_done = 0;
  endtask

  task automatic launch(input int m0, input int m1, input int m2,
                        input int s0, input int s1, input int s2, output int beats);
    max0 = m0[DW-1:0]; max1 = m1[DW-1:0]; max2 = m2[DW-1:0];
    stride0 = s0[DW-1:0]; stride1 = s1[DW-1:0]; stride2 = s2[DW-1:0];
    out_ready = 1'b1;
    start = 1'b1;
    beats = push_pass(m0, m1, m2, s0, s1, s2);
    tick();
    start = 1'b0;
    chk("valid_after_start", out_valid, 1);
    chk("busy_in_run", busy, 1);
  endtask

  // rmode 0: always ready; 1: random ready; 2: stall 3 cycles at count0==2.
  task automatic run_pass(input int m0, input int m1, input int m2,
                          input int s0, input int s1, input int s2, input int rmode);
    int beats, n, hc;
    launch(m0, m1, m2, s0, s1, s2, beats);
    n = 0; hc = 0;
    while (1) begin
      if (done) begin start = 1'b0; break; end
      if (n > 20000) begin
        checks++; errors++;
        $display("FAIL pass_timeout actual=%0d expected=%0d", n, beats);
        reset = 1'b0; start = 1'b0; tick(); reset = 1'b1; flush();
        return;
      end
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = ($urandom % 3) != 0;
      else if (count0 == 4'd2 && hc < 3) begin out_ready = 1'b0; hc++; end
      else out_ready = 1'b1;
      start = ($urandom % 8) == 0;
      tick();
      n++;
    end
    if (rmode == 0) chk("pass_cycles", n, beats);
    if (rmode == 2) chk("pass_cycles_stall", n, beats + 3);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_idle_after_done", busy, 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_counts"}, {count2, count1, count0}, 0);
  endtask

  initial begin
    int b;
    reset = 1'b0; clear = 1'b0; start = 1'b0; out_ready = 1'b0;
    max0 = '0; max1 = '0; max2 = '0; stride0 = '0; stride1 = '0; stride2 = '0;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();

    // Directed cases.
    run_pass(3, 0, 0, 1, 0, 0, 0);
    run_pass(5, 1, 0, 2, 1, 0, 0);
    run_pass(3, 0, 0, 1, 0, 0, 2);
    run_pass(7, 2, 0, 0, 1, 0, 1);
    run_pass(15, 15, 0, 15, 0, 0, 0);

    // Clear on the second beat, then a full fresh sweep.
    launch(3, 0, 0, 1, 0, 0, b);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    flush();
    chk_zero("clear");
    tick();
    chk_zero("clear_hold");
    run_pass(3, 0, 0, 1, 0, 0, 0);

    // Reset mid-pass with start high: start must not be honoured.
    launch(5, 2, 1, 1, 1, 1, b);
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    reset = 1'b1; start = 1'b0;
    flush();
    chk_zero("reset_mid");
    tick();
    chk_zero("reset_no_start");

    // Randomized back-to-back passes.
    for (int p = 0; p < 25; p++) begin
      int m0, s0;
      if ((p % 5) == 4) begin m0 = $urandom_range(0, 15); s0 = $urandom_range(0, 15); end
      else begin m0 = $urandom_range(0, 7); s0 = $urandom_range(0, 3); end
      run_pass(m0, $urandom_range(0, 7), $urandom_range(0, 7),
               s0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    tick();
    chk("queue_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/loop_count_down_nest.md
Name: loop_count_down_nest

Overview:
- Three-level nested loop index generator that counts DOWN from per-level max to 0 by per-level stride.
- Emits one index tuple per valid/ready beat; consumer side of the up-counting loop counters.
- Used by readback paths that drain buffers in reverse order.
- Level 0 is innermost; it carries into level 1, which carries into level 2.

Parameters:
DATA_WIDTH, 4, width of every max, stride and count field

Ports:
clk  input  1  clock
reset  input  1  synchronous active-low reset
clear  input  1  synchronous abort, active-high; returns block to IDLE
start  input  1  launch a pass; sampled only in IDLE
max0  input  DATA_WIDTH  level-0 start value, latched on start
max1  input  DATA_WIDTH  level-1 start value, latched on start
max2  input  DATA_WIDTH  level-2 start value, latched on start
stride0  input  DATA_WIDTH  level-0 decrement, latched on start
stride1  input  DATA_WIDTH  level-1 decrement, latched on start
stride2  input  DATA_WIDTH  level-2 decrement, latched on start
out_ready  input  1  consumer accepts current tuple
out_valid  output  1  tuple on count0..2 is valid
count0  output  DATA_WIDTH  level-0 index
count1  output  DATA_WIDTH  level-1 index
count2  output  DATA_WIDTH  level-2 index
last0  output  1  count0 is final value of its sweep
last1  output  1  count1 is final value of its sweep
last2  output  1  count2 is final value of its sweep
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset: clk and reset as named; reset is synchronous and active-low, the only reset. On reset low at a clk edge: state=IDLE; all counts, latched max/stride, out_valid, busy and done go to 0. reset has priority over clear; clear has priority over start and handshakes.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1.
  - Same edge: latch max0..2 and stride0..2; load countN <= maxN.
  - out_valid=1 from the next cycle, so tuple latency from start is 1 cycle.
- RUN:
  - out_valid=1.
  - A beat is a cycle with out_valid & out_ready.
  - Without a beat, all outputs hold stable.
- Per-level wrap condition W_N:
  - W_N = (countN == 0) | (countN < strideN) | (strideN == 0).
  - stride 0 therefore yields exactly one value per sweep.
  - lastN = W_N, combinational from the registered count and latched stride; lastN is 0 when out_valid=0.
- On a beat:
  - Level 0: if !W_0, count0 -= stride0; else count0 <= latched max0 and carry into level 1.
  - Level 1 steps only on a carry: same decrement/wrap rule, with carry into level 2.
  - Level 2 steps only on a carry from level 1.
  - No underflow: subtraction occurs only when countN >= strideN.
- Final beat is a beat with last0 & last1 & last2.
  - Next state DONE; out_valid=0.
  - Counts reload to the latched max values (value not observed).
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- busy=1 in RUN and DONE; 0 in IDLE.
- start outside IDLE is ignored; it does not relatch or restart.
- clear=1 (reset high), any state: next state IDLE; out_valid, busy and counts go to 0; no done pulse. A beat in the same cycle is discarded.
- Beats per pass = product over levels of sweep lengths, where sweep length = floor(max/stride)+1 (1 if stride=0).
  - Example: max=5, stride=2 gives 5,3,1 (3 values; sweep ends at 1, not 0).
- Back-to-back passes: start may be asserted in the IDLE cycle directly after DONE.

Test Plan:
- Basic sweep: max0=3, stride0=1, max1=max2=0, out_ready=1, start pulse -> count0 = 3,2,1,0 on 4 consecutive cycles; last0 only on 0; done pulses 1 cycle after value 0; busy falls the cycle after done.
- Non-dividing stride: max0=5, stride0=2, max1=1, stride1=1, max2=0 -> tuples (c1,c0) = (1,5),(1,3),(1,1),(0,5),(0,3),(0,1); last0 on c0=1; final beat (0,1) has last0=last1=last2=1.
- Backpressure: as basic sweep, out_ready low for 3 cycles while count0=2 -> count0 holds 2 with out_valid=1; resumes 1,0 after ready returns; total beats still 4.
- Stride zero and start ignored: max0=7, stride0=0, max1=2, stride1=1 -> 3 beats, count0=7 each, count1 = 2,1,0; a start pulse mid-pass changes nothing.
- Clear mid-pass: clear asserted on second beat of basic sweep -> next cycle out_valid=0, busy=0, counts 0, no done; a new start gives a full 3,2,1,0 sweep.
- Reset mid-pass: reset low for 1 cycle during RUN with start=1 -> all outputs 0 and state IDLE after that edge; start is not honoured in the reset cycle.
